// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA store pushes bytes into a FIFO,
// STATUS read reports overflow/frame/FIFO flags, tx emits 8N1 frames.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned BIT_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 overflow;
  logic [7:0]           shreg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [2:0]           bit_idx;

  logic fifo_empty;
  logic fifo_full;
  logic busy_frame;
  logic bit_end;
  logic push_req;
  logic clr_req;
  logic pop;
  logic push;
  logic ovf_event;
  logic unused_data_hi;

  assign unused_data_hi = ^data_in[31:8];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign busy_frame = (state != IDLE);
  assign busy       = busy_frame | ~fifo_empty;
  assign bit_end    = (bit_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1));

  // The FSM pops when idle or at the last cycle of STOP, so frames chain with no gap.
  assign pop       = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_end));
  assign push_req  = wr_en & (addr == BASE_ADDR);
  assign clr_req   = wr_en & (addr == STATUS_ADDR);
  assign push      = push_req & (~fifo_full | pop);
  assign ovf_event = push_req & fifo_full & ~pop;

  always_comb begin
    data_out = '0;
    if (addr == STATUS_ADDR) begin
      data_out = {27'b0, overflow, busy_frame, fifo_empty, fifo_full, 1'b0};
    end
  end

  // FIFO storage; a full-FIFO push with a same-cycle pop overwrites the slot being read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (clr_req) begin
        overflow <= 1'b0;
      end
    end
  end

  // Serializer: the shift register moves right so tx always takes the current LSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shreg   <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= mem[rd_ptr];
            tx      <= 1'b0;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (pop) begin
              shreg <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed stores, expected frames queued to a
// scoreboard that a tx-line monitor decodes and compares.
module tb_mmio_uart_tx;

  localparam logic [31:0] TXDATA = 32'h0000_0400;
  localparam logic [31:0] STATUS = 32'h0000_0404;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        tx;
  logic        busy;

  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b1;
  exp_t exp_q[$];

  mmio_uart_tx #(
    .BASE_ADDR(TXDATA),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out),
    .tx(tx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called at a negedge; the store lands on the following posedge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    addr    = a;
    data_in = d;
    @(negedge clk);
    wr_en   = 1'b0;
    addr    = '0;
  endtask

  task automatic read_status(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, data_out, exp);
    addr = '0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input bit b2b);
    exp_t e;
    e.data = d;
    e.b2b  = b2b;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // Monitor: bit k of a frame is sampled mid-period, 4*k+2 cycles after the start edge.
  initial begin : monitor
    int         idle_cnt;
    logic [7:0] got;
    logic       start_bit;
    logic       stop_bit;
    exp_t       e;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || reset || tx !== 1'b0) begin
        idle_cnt++;
      end else begin
        repeat (2) @(negedge clk);
        start_bit = tx;
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(negedge clk);
          got[b] = tx;
        end
        repeat (4) @(negedge clk);
        stop_bit = tx;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", {24'b0, got}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", {24'b0, got}, {24'b0, e.data});
          check("frame_start_stop", {30'b0, start_bit, stop_bit}, 32'd1);
          if (e.b2b) begin
            check("frame_gap", 32'(idle_cnt), 32'd1);
          end
        end
        idle_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n;
    int lows;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    read_status("reset_status", STATUS, 32'h4);

    // Store to an unrelated address is ignored.
    store(32'h0000_0010, 32'h99);
    check("ignored_busy", 32'(busy), 32'd0);
    read_status("ignored_status", STATUS, 32'h4);

    // Single byte 0x0A: one-cycle latency, 40-cycle frame.
    expect_frame(8'h0A, 1'b0);
    store(TXDATA, 32'h0A);
    check("latency_tx_before", 32'(tx), 32'd1);
    @(negedge clk);
    check("latency_tx_fall", 32'(tx), 32'd0);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_len", 32'(n), 32'd40);
    wait_idle("idle_single");

    // Burst 0x41..0x46: sixth store overflows.
    expect_frame(8'h41, 1'b0);
    for (int i = 2; i <= 5; i++) expect_frame(8'h40 + 8'(i), 1'b1);
    for (int i = 1; i <= 6; i++) store(TXDATA, 32'h40 + 32'(i));
    read_status("burst_status", STATUS, 32'h1A);
    check("burst_busy", 32'(busy), 32'd1);
    store(STATUS, 32'h0);
    read_status("clear_status", STATUS, 32'h0A);
    read_status("other_addr", 32'h0000_0408, 32'h0);

    // Push while full on the edge frame 0x41 ends STOP (edge 41 after first store).
    repeat (34) @(negedge clk);
    expect_frame(8'h47, 1'b1);
    store(TXDATA, 32'h47);
    read_status("full_pop_status", STATUS, 32'h0A);
    wait_idle("idle_burst");

    // Reset 15 cycles into frame 0x55 with two bytes queued.
    mon_en = 1'b0;
    store(TXDATA, 32'h55);
    store(TXDATA, 32'h66);
    store(TXDATA, 32'h77);
    repeat (13) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    read_status("abort_status", STATUS, 32'h4);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_frames_after_reset", 32'(lows), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
